// File: rtl/rs_encode_stream_out_ctrl_if.sv
// Handshake and metadata bundle between the RS encoder output sequencer and its
// neighbours: the input controller, the RS units, the datapath mux and the destination.
interface rs_encode_stream_out_ctrl_if #(
  parameter int NUM_RS_UNITS   = 4,
  parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
  parameter int BLOCK_CNT_W    = 16
);
  logic                      in_ctrl_out_ctrl_val;
  logic                      out_ctrl_in_ctrl_rdy;
  logic [BLOCK_CNT_W-1:0]    in_ctrl_out_ctrl_num_blocks;
  logic [NUM_RS_UNITS-1:0]   rs_units_out_ctrl_val;
  logic [NUM_RS_UNITS-1:0]   out_ctrl_rs_units_rdy;
  logic [NUM_RS_UNITS_W-1:0] out_ctrl_out_datap_unit_sel;
  logic                      out_ctrl_out_datap_store_meta;
  logic                      stream_encoder_dst_resp_val;
  logic                      dst_stream_encoder_resp_rdy;
  logic                      stream_encoder_dst_resp_data_val;
  logic                      dst_stream_encoder_resp_data_rdy;
  logic                      stream_encoder_dst_resp_data_last;

  modport master (
    input  in_ctrl_out_ctrl_val, in_ctrl_out_ctrl_num_blocks, rs_units_out_ctrl_val,
           dst_stream_encoder_resp_rdy, dst_stream_encoder_resp_data_rdy,
    output out_ctrl_in_ctrl_rdy, out_ctrl_rs_units_rdy, out_ctrl_out_datap_unit_sel,
           out_ctrl_out_datap_store_meta, stream_encoder_dst_resp_val,
           stream_encoder_dst_resp_data_val, stream_encoder_dst_resp_data_last
  );

  modport slave (
    output in_ctrl_out_ctrl_val, in_ctrl_out_ctrl_num_blocks, rs_units_out_ctrl_val,
           dst_stream_encoder_resp_rdy, dst_stream_encoder_resp_data_rdy,
    input  out_ctrl_in_ctrl_rdy, out_ctrl_rs_units_rdy, out_ctrl_out_datap_unit_sel,
           out_ctrl_out_datap_store_meta, stream_encoder_dst_resp_val,
           stream_encoder_dst_resp_data_val, stream_encoder_dst_resp_data_last
  );
endinterface

// File: rtl/rs_encode_stream_out_ctrl.sv
// Output sequencer for the streaming RS encoder: header beat, then round-robin block drain.
// One cycle to accept metadata; data valid/last follow the selected unit, unit rdy passes dst rdy through.
module rs_encode_stream_out_ctrl #(
  parameter int NUM_RS_UNITS   = 4,
  parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
  parameter int BLOCK_LINES    = 4,
  parameter int BLOCK_LINES_W  = $clog2(BLOCK_LINES + 1),
  parameter int BLOCK_CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  rs_encode_stream_out_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    READY     = 2'd0,
    SEND_META = 2'd1,
    DRAIN     = 2'd2
  } state_e;

  localparam logic [NUM_RS_UNITS_W-1:0] LAST_UNIT = NUM_RS_UNITS_W'(NUM_RS_UNITS - 1);
  localparam logic [BLOCK_LINES_W-1:0]  LAST_LINE = BLOCK_LINES_W'(BLOCK_LINES - 1);

  state_e                    state_q;
  logic [NUM_RS_UNITS_W-1:0] unit_sel_q;
  logic [BLOCK_LINES_W-1:0]  line_cnt_q;
  logic [BLOCK_CNT_W-1:0]    blk_cnt_q;
  logic                      in_rdy_q;
  logic                      store_meta_q;
  logic                      resp_val_q;

  logic sel_val;
  logic beat;
  logic last_blk;

  assign sel_val  = bus.rs_units_out_ctrl_val[unit_sel_q];
  assign last_blk = (blk_cnt_q == BLOCK_CNT_W'(1));

  assign bus.out_ctrl_in_ctrl_rdy          = in_rdy_q;
  assign bus.out_ctrl_out_datap_store_meta = store_meta_q;
  assign bus.stream_encoder_dst_resp_val   = resp_val_q;
  assign bus.out_ctrl_out_datap_unit_sel   = unit_sel_q;

  // Only the unit whose turn it is sees the destination ready; the others hold their lines.
  always_comb begin
    bus.stream_encoder_dst_resp_data_val  = 1'b0;
    bus.stream_encoder_dst_resp_data_last = 1'b0;
    bus.out_ctrl_rs_units_rdy             = '0;
    beat                                  = 1'b0;
    case (state_q)
      READY, SEND_META: begin
      end
      DRAIN: begin
        bus.stream_encoder_dst_resp_data_val      = sel_val;
        bus.stream_encoder_dst_resp_data_last     = sel_val & (line_cnt_q == LAST_LINE) & last_blk;
        bus.out_ctrl_rs_units_rdy[unit_sel_q]     = bus.dst_stream_encoder_resp_data_rdy;
        beat = sel_val & bus.dst_stream_encoder_resp_data_rdy;
      end
      default: begin
        bus.stream_encoder_dst_resp_data_val  = 1'bx;
        bus.stream_encoder_dst_resp_data_last = 1'bx;
        bus.out_ctrl_rs_units_rdy             = 'x;
        beat                                  = 1'bx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= READY;
      unit_sel_q   <= '0;
      line_cnt_q   <= '0;
      blk_cnt_q    <= '0;
      in_rdy_q     <= 1'b1;
      store_meta_q <= 1'b1;
      resp_val_q   <= 1'b0;
    end else begin
      case (state_q)
        READY: begin
          if (bus.in_ctrl_out_ctrl_val) begin
            blk_cnt_q    <= bus.in_ctrl_out_ctrl_num_blocks;
            unit_sel_q   <= '0;
            line_cnt_q   <= '0;
            in_rdy_q     <= 1'b0;
            store_meta_q <= 1'b0;
            resp_val_q   <= 1'b1;
            state_q      <= SEND_META;
          end
        end
        SEND_META: begin
          if (bus.dst_stream_encoder_resp_rdy) begin
            resp_val_q <= 1'b0;
            if (blk_cnt_q == '0) begin
              in_rdy_q     <= 1'b1;
              store_meta_q <= 1'b1;
              state_q      <= READY;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (beat) begin
            if (line_cnt_q == LAST_LINE) begin
              line_cnt_q <= '0;
              blk_cnt_q  <= blk_cnt_q - BLOCK_CNT_W'(1);
              if (last_blk) begin
                unit_sel_q   <= '0;
                in_rdy_q     <= 1'b1;
                store_meta_q <= 1'b1;
                state_q      <= READY;
              end else if (unit_sel_q == LAST_UNIT) begin
                // explicit wrap so a non-power-of-2 unit count never selects a missing unit
                unit_sel_q <= '0;
              end else begin
                unit_sel_q <= unit_sel_q + NUM_RS_UNITS_W'(1);
              end
            end else begin
              line_cnt_q <= line_cnt_q + BLOCK_LINES_W'(1);
            end
          end
        end
        default: begin
          state_q      <= state_e'('x);
          unit_sel_q   <= 'x;
          line_cnt_q   <= 'x;
          blk_cnt_q    <= 'x;
          in_rdy_q     <= 1'bx;
          store_meta_q <= 1'bx;
          resp_val_q   <= 1'bx;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// Directed bench for rs_encode_stream_out_ctrl: a 4-unit and a 3-unit instance share stimulus.
module tb_rs_encode_stream_out_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val = 1'b0;
  logic [15:0] num = '0;
  logic [3:0]  unit_val = 4'hF;
  logic        resp_rdy = 1'b1;
  logic        data_rdy = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  int sel4[$];
  int sel3[$];
  int hdr4, lastn4, lastpos4, viol4;
  int lastn3, lastpos3, viol3;

  always #5 clk = ~clk;

  rs_encode_stream_out_ctrl_if #(.NUM_RS_UNITS(4)) if4 ();
  rs_encode_stream_out_ctrl_if #(.NUM_RS_UNITS(3)) if3 ();

  assign if4.in_ctrl_out_ctrl_val             = val;
  assign if4.in_ctrl_out_ctrl_num_blocks      = num;
  assign if4.rs_units_out_ctrl_val            = unit_val;
  assign if4.dst_stream_encoder_resp_rdy      = resp_rdy;
  assign if4.dst_stream_encoder_resp_data_rdy = data_rdy;
  assign if3.in_ctrl_out_ctrl_val             = val;
  assign if3.in_ctrl_out_ctrl_num_blocks      = num;
  assign if3.rs_units_out_ctrl_val            = unit_val[2:0];
  assign if3.dst_stream_encoder_resp_rdy      = resp_rdy;
  assign if3.dst_stream_encoder_resp_data_rdy = data_rdy;

  rs_encode_stream_out_ctrl #(.NUM_RS_UNITS(4), .BLOCK_LINES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  rs_encode_stream_out_ctrl #(.NUM_RS_UNITS(3), .BLOCK_LINES(4)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    sel4.delete(); sel3.delete();
    hdr4 = 0; lastn4 = 0; lastpos4 = -1; viol4 = 0;
    lastn3 = 0; lastpos3 = -1; viol3 = 0;
  endtask

  // Beat recorder: inputs settle 1ns after posedge, so the negedge sees what the next edge consumes.
  always @(negedge clk) begin
    if (!rst) begin
      if (if4.stream_encoder_dst_resp_val && resp_rdy) hdr4++;
      if (if4.stream_encoder_dst_resp_data_val && data_rdy) begin
        if (hdr4 == 0) viol4++;
        sel4.push_back(int'(if4.out_ctrl_out_datap_unit_sel));
        if (if4.stream_encoder_dst_resp_data_last) begin
          lastn4++;
          lastpos4 = sel4.size() - 1;
        end
      end
      if ((if4.out_ctrl_rs_units_rdy & ~(4'b0001 << if4.out_ctrl_out_datap_unit_sel)) != 4'b0) viol4++;
      if (if4.stream_encoder_dst_resp_data_last && !if4.stream_encoder_dst_resp_data_val) viol4++;
      if (if3.stream_encoder_dst_resp_data_val && data_rdy) begin
        sel3.push_back(int'(if3.out_ctrl_out_datap_unit_sel));
        if (if3.stream_encoder_dst_resp_data_last) begin
          lastn3++;
          lastpos3 = sel3.size() - 1;
        end
      end
      if ((if3.out_ctrl_rs_units_rdy & ~(3'b001 << if3.out_ctrl_out_datap_unit_sel)) != 3'b0) viol3++;
      if (if3.out_ctrl_out_datap_unit_sel > 2'd2) viol3++;
    end
  end

  task automatic issue(input int nb);
    num = 16'(nb);
    val = 1'b1;
    step();
    val = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!(if4.out_ctrl_in_ctrl_rdy && if3.out_ctrl_in_ctrl_rdy) && n < 3000) begin
      if (rnd) begin
        data_rdy = 1'($urandom_range(0, 1));
        unit_val = 4'($urandom_range(0, 15));
      end
      step();
      n++;
    end
    check_eq("done_in_budget", 32'(n < 3000), 32'd1);
    data_rdy = 1'b1;
    unit_val = 4'hF;
  endtask

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "_in_rdy"},   32'(if4.out_ctrl_in_ctrl_rdy), 32'd1);
    check_eq({tag, "_resp_val"}, 32'(if4.stream_encoder_dst_resp_val), 32'd0);
    check_eq({tag, "_data_val"}, 32'(if4.stream_encoder_dst_resp_data_val), 32'd0);
    check_eq({tag, "_last"},     32'(if4.stream_encoder_dst_resp_data_last), 32'd0);
    check_eq({tag, "_unit_rdy"}, 32'(if4.out_ctrl_rs_units_rdy), 32'd0);
    check_eq({tag, "_sel"},      32'(if4.out_ctrl_out_datap_unit_sel), 32'd0);
  endtask

  task automatic check_drain(input string tag, input int nb);
    check_eq({tag, "_hdr"},      32'(hdr4), 32'd1);
    check_eq({tag, "_beats4"},   32'(sel4.size()), 32'(4 * nb));
    check_eq({tag, "_beats3"},   32'(sel3.size()), 32'(4 * nb));
    check_eq({tag, "_lastn"},    32'(lastn4), 32'd1);
    check_eq({tag, "_lastpos"},  32'(lastpos4), 32'(4 * nb - 1));
    check_eq({tag, "_lastn3"},   32'(lastn3), 32'd1);
    check_eq({tag, "_viol4"},    32'(viol4), 32'd0);
    check_eq({tag, "_viol3"},    32'(viol3), 32'd0);
    for (int i = 0; i < sel4.size(); i++) check_eq({tag, "_sel4"}, 32'(sel4[i]), 32'((i / 4) % 4));
    for (int i = 0; i < sel3.size(); i++) check_eq({tag, "_sel3"}, 32'(sel3[i]), 32'((i / 4) % 3));
  endtask

  initial begin
    clear_mon();
    step();
    step();
    check_outputs_idle("reset");
    rst = 1'b0;

    // 3 blocks, everything ready: unit 0,1,2 four lines each
    clear_mon();
    issue(3);
    wait_done(1'b0);
    check_drain("b3", 3);
    check_outputs_idle("b3_end");
    check_eq("b3_store_meta", 32'(if4.out_ctrl_out_datap_store_meta), 32'd1);

    // header-only request
    clear_mon();
    issue(0);
    check_eq("b0_in_rdy_lo",   32'(if4.out_ctrl_in_ctrl_rdy), 32'd0);
    check_eq("b0_resp_val",    32'(if4.stream_encoder_dst_resp_val), 32'd1);
    check_eq("b0_store_meta",  32'(if4.out_ctrl_out_datap_store_meta), 32'd0);
    step();
    check_eq("b0_in_rdy_back", 32'(if4.out_ctrl_in_ctrl_rdy), 32'd1);
    check_eq("b0_resp_done",   32'(if4.stream_encoder_dst_resp_val), 32'd0);
    check_eq("b0_hdr",         32'(hdr4), 32'd1);
    check_eq("b0_beats",       32'(sel4.size()), 32'd0);

    // 6 blocks: wraps past the last unit on both instances
    clear_mon();
    issue(6);
    wait_done(1'b0);
    check_drain("b6", 6);

    // random dst rdy and unit valids
    clear_mon();
    issue(4);
    wait_done(1'b1);
    check_drain("rnd", 4);

    // destination stalls the header for 5 cycles
    clear_mon();
    resp_rdy = 1'b0;
    issue(1);
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_resp_val", 32'(if4.stream_encoder_dst_resp_val), 32'd1);
      check_eq("stall_data_val", 32'(if4.stream_encoder_dst_resp_data_val), 32'd0);
      step();
    end
    resp_rdy = 1'b1;
    wait_done(1'b0);
    check_drain("stall", 1);

    // reset during block 2 of 4
    clear_mon();
    issue(4);
    begin
      int n = 0;
      while (sel4.size() < 5 && n < 100) begin
        step();
        n++;
      end
      check_eq("mid_reached_blk2", 32'(n < 100), 32'd1);
    end
    check_eq("mid_sel_blk2", 32'(if4.out_ctrl_out_datap_unit_sel), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outputs_idle("mid_rst");
    clear_mon();
    issue(1);
    wait_done(1'b0);
    check_drain("post_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
